// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the reg_file_struct register file.
package reg_file_pkg;

    localparam int WIDTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [WIDTH-1:0]    word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [NUM_REGS-1:0] onehot_t;

endpackage

// File: rtl/reg_file_struct_reg_cell.sv
// One register of the file: a WIDTH-bit flop with synchronous active-low clear
// and a load enable. Clear wins over load.
module reg_cell
    import reg_file_pkg::*;
(
    input  logic  clk,
    input  logic  nClear,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    // NOTE: sequential state uses non-blocking (<=) so every cell samples its
    // inputs from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!nClear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_struct.sv
// 16x16 register file: two combinational read ports (A, B), one synchronous
// write port (C). Optional A/B write forwarding when WRITE_BYPASS_EN is defined.
module reg_file_struct
    import reg_file_pkg::*;
(
    input  logic  clk,
    input  logic  nClear,
    input  logic  load,
    input  addr_t Caddr,
    input  word_t C,
    input  addr_t Aaddr,
    input  addr_t Baddr,
    output word_t A,
    output word_t B
);

    onehot_t we;
    word_t   q [NUM_REGS];
    word_t   a_raw;
    word_t   b_raw;

    // NOTE: every always_comb output gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        we = '0;
        if (load) begin
            we[Caddr] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        reg_cell u_cell (
            .clk    (clk),
            .nClear (nClear),
            .en     (we[i]),
            .d      (C),
            .q      (q[i])
        );
    end

    always_comb begin
        a_raw = q[Aaddr];
        b_raw = q[Baddr];
    end

`ifdef WRITE_BYPASS_EN
    // Forward the pending write so a same-cycle reader sees the new value.
    logic fwd_ok;
    assign fwd_ok = load && nClear;
    assign A = (fwd_ok && (Aaddr == Caddr)) ? C : a_raw;
    assign B = (fwd_ok && (Baddr == Caddr)) ? C : b_raw;
`else
    assign A = a_raw;
    assign B = b_raw;
`endif

endmodule

// File: tb/tb_reg_file_struct.sv
// Scoreboard bench for reg_file_struct: stimulus pushes expected read data,
// a monitor pops and compares. Honours WRITE_BYPASS_EN like the design.
module tb_reg_file_struct;

    logic        clk = 1'b0;
    logic        nClear;
    logic        load;
    logic [3:0]  Caddr, Aaddr, Baddr;
    logic [15:0] C;
    logic [15:0] A, B;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t exp_q[$];
    event present;

    logic [15:0] mem [16];
    bit          model_valid = 0;

    reg_file_struct dut (
        .clk    (clk),
        .nClear (nClear),
        .load   (load),
        .Caddr  (Caddr),
        .C      (C),
        .Aaddr  (Aaddr),
        .Baddr  (Baddr),
        .A      (A),
        .B      (B)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] addr);
`ifdef WRITE_BYPASS_EN
        if (load && nClear && addr == Caddr) return C;
`endif
        return mem[addr];
    endfunction

    // Drive one cycle of inputs, predict pre-edge reads, then advance the model.
    task automatic step(input string tag, input bit ncl, input bit ld, input logic [3:0] ca,
                        input logic [15:0] cd, input logic [3:0] aa, input logic [3:0] ba);
        exp_t e;
        @(negedge clk);
        nClear = ncl; load = ld; Caddr = ca; C = cd; Aaddr = aa; Baddr = ba;
        #1;
        if (model_valid) begin
            e.tag = tag;
            e.a   = model_read(aa);
            e.b   = model_read(ba);
            exp_q.push_back(e);
            -> present;
        end
        @(posedge clk);
        if (!ncl) begin
            foreach (mem[i]) mem[i] = '0;
            model_valid = 1;
        end else if (ld) begin
            mem[ca] = cd;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(present);
            #1;
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_A"}, A, e.a);
                check({e.tag, "_B"}, B, e.b);
            end
        end
    end

    initial begin : stim
        int drain;
        nClear = 1; load = 0; Caddr = 0; C = 0; Aaddr = 0; Baddr = 0;

        // Reset held for several edges, sweeping all read addresses
        repeat (3) step("reset", 0, 1, 4'd7, 16'hffff, 0, 0);
        for (int i = 0; i < 16; i++)
            step("reset_sweep", 0, 0, 0, 0, 4'(i), 4'(15 - i));

        // Fill k=1..15 with k+1, then read them back
        for (int k = 1; k < 16; k++)
            step("fill", 1, 1, 4'(k), 16'(k + 1), 4'(k), 4'd0);
        for (int k = 0; k < 16; k++)
            step("fill_read", 1, 0, 0, 0, 4'(k), 4'(15 - k));

        // Load disabled: C/Caddr ignored
        repeat (2) step("load_dis", 1, 0, 4'd8, 16'd8, 4'd8, 4'd8);
        step("load_dis_read", 1, 0, 0, 0, 4'd8, 4'd9);

        // Sync clear: pre-edge still shows 5/6, then 0
        step("clear", 0, 0, 0, 0, 4'd4, 4'd5);
        step("clear_read", 1, 0, 0, 0, 4'd4, 4'd5);

        // Rewrite after clear; first write overlaps the clear release
        step("clr_wr", 0, 1, 4'd4, 16'd99, 4'd4, 4'd5);
        step("rewrite4", 1, 1, 4'd4, 16'd11, 4'd4, 4'd5);
        step("rewrite5", 1, 1, 4'd5, 16'd15, 4'd4, 4'd5);
        step("rewrite_read", 1, 0, 0, 0, 4'd4, 4'd5);

        // Same-address read during write
        step("rdw", 1, 1, 4'd3, 16'h1234, 4'd3, 4'd3);
        step("rdw_after", 1, 0, 0, 0, 4'd3, 4'd3);

        // Register 0 is writable
        step("r0_wr", 1, 1, 4'd0, 16'hbeef, 4'd0, 4'd1);
        step("r0_read", 1, 0, 0, 0, 4'd0, 4'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++)
            step("rand", ($urandom_range(0, 31) != 0), $urandom_range(0, 1),
                 4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
